mrv1_th_barrier: RTL and testbench
==================================

// Module: mrv1_th_barrier
// PURPOSE
//  Thread-synchronisation backend fed by mrv1_th_ctl. Tracks per-barrier arrival counts and masks of parked threads.
//  Releases all waiters when a barrier fills, and maintains the thread-active mask updated by wspawn/exit.
//  Sits between the thread-control execute unit and the thread scheduler/fetch, which consumes the stall, release and active masks.
// PARAMETERS
//  NUM_THREADS_P        8                           hardware threads
//  num_barriers_p       8                           barrier table entries
//  wid_width_lp         $clog2(NUM_THREADS_P)       thread id width
//  barrier_id_width_lp  $clog2(num_barriers_p)      barrier id width
// PORTS
//  clk_i                 in   1              clock
//  rst_i                 in   1              asynchronous reset, active-high
//  barrier_vld_i         in   1              barrier arrival, one per cycle, always accepted
//  barrier_id_i          in   barrier_id_w   barrier index
//  barrier_size_m1_i     in   wid_w          participating threads minus one
//  barrier_wid_i         in   wid_w          arriving thread id
//  wspawn_vld_i          in   1              spawn request
//  wspawn_wmask_i        in   NUM_THREADS_P  threads to activate
//  wspawn_pc_i           in   32             start pc for spawned threads
//  exit_vld_i            in   1              thread exit
//  exit_wid_i            in   wid_w          exiting thread id
//  th_active_mask_o      out  NUM_THREADS_P  active threads
//  th_stall_mask_o       out  NUM_THREADS_P  threads parked at any barrier
//  release_vld_o         out  1              one-cycle release pulse
//  release_mask_o        out  NUM_THREADS_P  threads released this pulse
//  spawn_vld_o           out  1              registered spawn to fetch
//  spawn_mask_o          out  NUM_THREADS_P  registered wspawn_wmask_i
//  spawn_pc_o            out  32             registered wspawn_pc_i
//  err_o                 out  1              sticky protocol error
// BEHAVIOUR
//  Reset values:
//   - th_active_mask_o = 'b1 (thread 0 only).
//   - Every other output is 0.
//   - All table entries invalid, count 0, mask 0.
//  Reset mid-operation: entries cleared, parked threads dropped, no release pulse.
//  Entry state: vld, size_m1[wid_w], cnt[wid_w], mask[NUM_THREADS_P].
//  Arrival at entry id E with bit b = 1<<barrier_wid_i; eff_size = E.vld ? E.size_m1 : barrier_size_m1_i.
//   - Wait (E.cnt != eff_size): set E.vld, latch size_m1 if E was invalid, E.mask |= b, E.cnt++.
//   - Fill (E.cnt == eff_size): clear E. Next cycle release_vld_o = 1 and release_mask_o = E.mask | b.
//   - size_m1 == 0 fills on first arrival: thread released alone, never appears in the stall mask.
//  Latency:
//   - A parked thread appears in th_stall_mask_o the cycle after its arrival.
//   - On fill, the entry mask leaves th_stall_mask_o at the same edge release_vld_o rises.
//  th_stall_mask_o = OR of all valid entry masks (combinational from state).
//  release_vld_o is a single-cycle pulse; release_mask_o is 0 whenever release_vld_o is 0.
//  Errors: set err_o (sticky until reset). The arrival is then ignored and the entry is unchanged.
//   - Arriving thread already in E.mask.
//   - Valid entry and barrier_size_m1_i != E.size_m1.
//   - barrier_wid_i not in th_active_mask_o.
//  Active mask:
//   - next = (active & ~exit_bit) | (wspawn_vld_i ? wspawn_wmask_i : 0).
//   - Spawn wins on a same-cycle exit of the same thread.
//  spawn_vld_o/mask_o/pc_o: one-cycle registered copy of the wspawn inputs.
//  Exit of a parked thread: err_o set. Its mask bit stays until the barrier fills.
// TESTING
//  - Reset: active=0x01, stall=0, release_vld=0, err=0.
//  - wspawn mask=0xFE pc=0x100: next cycle spawn_vld=1 pc=0x100, active=0xFF.
//  - Barrier 3, size_m1=3, threads 0,1,2: stall=0x07, no release.
//    Thread 5 arrives: next cycle release_vld=1 mask=0x27, stall=0.
//  - Barrier 0 size_m1=0 by thread 4: release mask=0x10 next cycle, stall stays 0.
//  - Thread 1 arrives twice at barrier 2 (size_m1=2): err=1, entry cnt=1 mask=0x02.
//  - Barriers 1 and 6 partially filled, assert rst_i: stall=0, no release pulse, reuse works.

Source files
------------

// File: rtl/mrv1_th_barrier.sv
// Barrier table, thread-active mask and spawn register for the thread scheduler.
// Releases and spawns appear one cycle after their input. Arrivals are always accepted, with no backpressure.
module mrv1_th_barrier #(
    parameter int NUM_THREADS_P  = 8,
    parameter int num_barriers_p = 8,
    localparam int wid_width_lp        = $clog2(NUM_THREADS_P),
    localparam int barrier_id_width_lp = $clog2(num_barriers_p)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           barrier_vld_i,
    input  logic [barrier_id_width_lp-1:0] barrier_id_i,
    input  logic [wid_width_lp-1:0]        barrier_size_m1_i,
    input  logic [wid_width_lp-1:0]        barrier_wid_i,
    input  logic                           wspawn_vld_i,
    input  logic [NUM_THREADS_P-1:0]       wspawn_wmask_i,
    input  logic [31:0]                    wspawn_pc_i,
    input  logic                           exit_vld_i,
    input  logic [wid_width_lp-1:0]        exit_wid_i,
    output logic [NUM_THREADS_P-1:0]       th_active_mask_o,
    output logic [NUM_THREADS_P-1:0]       th_stall_mask_o,
    output logic                           release_vld_o,
    output logic [NUM_THREADS_P-1:0]       release_mask_o,
    output logic                           spawn_vld_o,
    output logic [NUM_THREADS_P-1:0]       spawn_mask_o,
    output logic [31:0]                    spawn_pc_o,
    output logic                           err_o
);

    logic                     ent_vld  [num_barriers_p];
    logic [wid_width_lp-1:0]  ent_size [num_barriers_p];
    logic [wid_width_lp-1:0]  ent_cnt  [num_barriers_p];
    logic [NUM_THREADS_P-1:0] ent_mask [num_barriers_p];

    logic                     sel_vld;
    logic [wid_width_lp-1:0]  sel_size;
    logic [wid_width_lp-1:0]  sel_cnt;
    logic [NUM_THREADS_P-1:0] sel_mask;
    logic [wid_width_lp-1:0]  eff_size;
    logic [NUM_THREADS_P-1:0] arr_bit;
    logic [NUM_THREADS_P-1:0] exit_bit;
    logic                     arr_bad;
    logic                     arr_ok;
    logic                     arr_fill;
    logic                     arr_wait;
    logic                     exit_bad;

    assign sel_vld  = ent_vld[barrier_id_i];
    assign sel_size = ent_size[barrier_id_i];
    assign sel_cnt  = ent_cnt[barrier_id_i];
    assign sel_mask = ent_mask[barrier_id_i];
    assign eff_size = sel_vld ? sel_size : barrier_size_m1_i;
    assign arr_bit  = NUM_THREADS_P'(1) << barrier_wid_i;
    assign exit_bit = NUM_THREADS_P'(1) << exit_wid_i;

    // A rejected arrival leaves the entry untouched; only the sticky error records it.
    assign arr_bad  = (|(sel_mask & arr_bit))
                    || (sel_vld && (barrier_size_m1_i != sel_size))
                    || !th_active_mask_o[barrier_wid_i];
    assign arr_ok   = barrier_vld_i && !arr_bad;
    assign arr_fill = arr_ok && (sel_cnt == eff_size);
    assign arr_wait = arr_ok && (sel_cnt != eff_size);
    assign exit_bad = exit_vld_i && (|(th_stall_mask_o & exit_bit));

    always_comb begin
        th_stall_mask_o = '0;
        for (int i = 0; i < num_barriers_p; i++) begin
            if (ent_vld[i]) begin
                th_stall_mask_o = th_stall_mask_o | ent_mask[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < num_barriers_p; i++) begin
                ent_vld[i]  <= 1'b0;
                ent_size[i] <= '0;
                ent_cnt[i]  <= '0;
                ent_mask[i] <= '0;
            end
        end else if (arr_fill) begin
            ent_vld[barrier_id_i]  <= 1'b0;
            ent_size[barrier_id_i] <= '0;
            ent_cnt[barrier_id_i]  <= '0;
            ent_mask[barrier_id_i] <= '0;
        end else if (arr_wait) begin
            ent_vld[barrier_id_i]  <= 1'b1;
            ent_size[barrier_id_i] <= eff_size;
            ent_cnt[barrier_id_i]  <= sel_cnt + wid_width_lp'(1);
            ent_mask[barrier_id_i] <= sel_mask | arr_bit;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            th_active_mask_o <= NUM_THREADS_P'(1);
            release_vld_o    <= 1'b0;
            release_mask_o   <= '0;
            spawn_vld_o      <= 1'b0;
            spawn_mask_o     <= '0;
            spawn_pc_o       <= '0;
            err_o            <= 1'b0;
        end else begin
            // Spawn is OR-ed in after the exit clear so it wins on a same-thread collision.
            th_active_mask_o <= (th_active_mask_o & ~(exit_vld_i ? exit_bit : '0))
                              | (wspawn_vld_i ? wspawn_wmask_i : '0);
            release_vld_o    <= arr_fill;
            release_mask_o   <= arr_fill ? (sel_mask | arr_bit) : '0;
            spawn_vld_o      <= wspawn_vld_i;
            spawn_mask_o     <= wspawn_wmask_i;
            spawn_pc_o       <= wspawn_pc_i;
            err_o            <= err_o | (barrier_vld_i && arr_bad) | exit_bad;
        end
    end

endmodule

// File: tb/tb_mrv1_th_barrier.sv
// Directed bench for mrv1_th_barrier: per-cycle compare against a set-based barrier model plus literal checks.
module tb_mrv1_th_barrier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        barrier_vld = 1'b0;
    logic [2:0]  barrier_id = '0;
    logic [2:0]  barrier_size_m1 = '0;
    logic [2:0]  barrier_wid = '0;
    logic        wspawn_vld = 1'b0;
    logic [7:0]  wspawn_wmask = '0;
    logic [31:0] wspawn_pc = '0;
    logic        exit_vld = 1'b0;
    logic [2:0]  exit_wid = '0;
    logic [7:0]  th_active_mask;
    logic [7:0]  th_stall_mask;
    logic        release_vld;
    logic [7:0]  release_mask;
    logic        spawn_vld;
    logic [7:0]  spawn_mask;
    logic [31:0] spawn_pc;
    logic        err;

    mrv1_th_barrier dut (
        .clk_i(clk), .rst_i(rst),
        .barrier_vld_i(barrier_vld), .barrier_id_i(barrier_id),
        .barrier_size_m1_i(barrier_size_m1), .barrier_wid_i(barrier_wid),
        .wspawn_vld_i(wspawn_vld), .wspawn_wmask_i(wspawn_wmask), .wspawn_pc_i(wspawn_pc),
        .exit_vld_i(exit_vld), .exit_wid_i(exit_wid),
        .th_active_mask_o(th_active_mask), .th_stall_mask_o(th_stall_mask),
        .release_vld_o(release_vld), .release_mask_o(release_mask),
        .spawn_vld_o(spawn_vld), .spawn_mask_o(spawn_mask), .spawn_pc_o(spawn_pc),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    // Model: each barrier is a set of parked threads; the arrival count is its population.
    bit [7:0]  m_set [8];
    bit        m_open [8];
    bit [2:0]  m_size [8];
    bit [7:0]  m_active;
    bit        m_rel_v;
    bit [7:0]  m_rel_m;
    bit        m_err;
    bit        m_sp_v;
    bit [7:0]  m_sp_m;
    bit [31:0] m_sp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit [7:0] m_stall();
        bit [7:0] s = '0;
        for (int i = 0; i < 8; i++) s |= m_set[i];
        return s;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_set[i] = '0; m_open[i] = 1'b0; m_size[i] = '0;
        end
        m_active = 8'h01; m_rel_v = 0; m_rel_m = '0; m_err = 0;
        m_sp_v = 0; m_sp_m = '0; m_sp_pc = '0;
    endtask

    task automatic m_step();
        bit [7:0] b;
        bit [7:0] parked;
        int e;
        int need;
        bit rej;
        parked = m_stall();
        m_rel_v = 0;
        m_rel_m = '0;
        if (barrier_vld) begin
            e = int'(barrier_id);
            b = 8'h01 << barrier_wid;
            need = m_open[e] ? int'(m_size[e]) : int'(barrier_size_m1);
            rej = (m_set[e] & b) != 0 || (m_open[e] && barrier_size_m1 != m_size[e])
                  || m_active[barrier_wid] == 1'b0;
            if (rej) m_err = 1;
            else if ($countones(m_set[e]) == need) begin
                m_rel_v = 1; m_rel_m = m_set[e] | b;
                m_set[e] = '0; m_open[e] = 0; m_size[e] = '0;
            end else begin
                if (!m_open[e]) m_size[e] = barrier_size_m1;
                m_open[e] = 1; m_set[e] |= b;
            end
        end
        if (exit_vld && parked[exit_wid]) m_err = 1;
        if (exit_vld) m_active[exit_wid] = 1'b0;
        if (wspawn_vld) m_active |= wspawn_wmask;
        m_sp_v = wspawn_vld; m_sp_m = wspawn_wmask; m_sp_pc = wspawn_pc;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("active", th_active_mask, m_active);
            chk("stall", th_stall_mask, m_stall());
            chk("rel_vld", release_vld, m_rel_v);
            chk("rel_mask", release_mask, m_rel_m);
            chk("spawn_vld", spawn_vld, m_sp_v);
            chk("spawn_mask", spawn_mask, m_sp_m);
            chk("spawn_pc", spawn_pc, m_sp_pc);
            chk("err", err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) m_step();
        #1;
        barrier_vld = 0; barrier_id = '0; barrier_size_m1 = '0; barrier_wid = '0;
        wspawn_vld = 0; wspawn_wmask = '0; wspawn_pc = '0;
        exit_vld = 0; exit_wid = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic arrive(input int id, input int sz, input int wid);
        barrier_vld = 1; barrier_id = 3'(id); barrier_size_m1 = 3'(sz); barrier_wid = 3'(wid);
        tick();
    endtask

    task automatic spawn(input logic [7:0] m, input logic [31:0] pc);
        wspawn_vld = 1; wspawn_wmask = m; wspawn_pc = pc;
        tick();
    endtask

    task automatic do_exit(input int wid);
        exit_vld = 1; exit_wid = 3'(wid);
        tick();
    endtask

    initial begin
        m_reset();
        #2 cmp_en = 1;
        do_reset();
        chk("rst_active", th_active_mask, 8'h01);
        chk("rst_stall", th_stall_mask, 8'h00);
        chk("rst_rel", release_vld, 1'b0);
        chk("rst_err", err, 1'b0);

        spawn(8'hFE, 32'h100);
        chk("spawn_vld_lit", spawn_vld, 1'b1);
        chk("spawn_pc_lit", spawn_pc, 32'h100);
        chk("active_ff", th_active_mask, 8'hFF);

        arrive(3, 3, 0); arrive(3, 3, 1); arrive(3, 3, 2);
        chk("b3_stall", th_stall_mask, 8'h07);
        chk("b3_norel", release_vld, 1'b0);
        arrive(3, 3, 5);
        chk("b3_rel", release_vld, 1'b1);
        chk("b3_mask", release_mask, 8'h27);
        chk("b3_stall0", th_stall_mask, 8'h00);
        tick();
        chk("b3_pulse", release_vld, 1'b0);

        arrive(0, 0, 4);
        chk("b0_mask", release_mask, 8'h10);
        chk("b0_stall", th_stall_mask, 8'h00);
        tick();

        exit_vld = 1; exit_wid = 3'd2; wspawn_vld = 1; wspawn_wmask = 8'h04;
        tick();
        chk("spawn_wins", th_active_mask, 8'hFF);
        do_exit(7);
        chk("exit7", th_active_mask, 8'h7F);

        arrive(2, 2, 1); arrive(2, 2, 1);
        chk("dup_err", err, 1'b1);
        chk("dup_stall", th_stall_mask, 8'h02);
        arrive(2, 2, 3);
        chk("b2_stall", th_stall_mask, 8'h0A);
        arrive(2, 2, 4);
        chk("b2_rel", release_mask, 8'h1A);

        arrive(1, 3, 0); arrive(1, 3, 1); arrive(6, 2, 3);
        chk("pre_rst_stall", th_stall_mask, 8'h0B);
        do_reset();
        chk("mid_rst_stall", th_stall_mask, 8'h00);
        chk("mid_rst_rel", release_vld, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        tick();
        chk("mid_rst_norel", release_vld, 1'b0);

        spawn(8'h02, 32'h200);
        arrive(1, 1, 0); arrive(1, 1, 1);
        chk("reuse_rel", release_mask, 8'h03);
        chk("reuse_err", err, 1'b0);
        tick();

        arrive(5, 1, 6);
        chk("inactive_err", err, 1'b1);
        chk("inactive_stall", th_stall_mask, 8'h00);
        do_reset();

        arrive(4, 3, 0);
        spawn(8'h02, 32'h0);
        arrive(4, 2, 1);
        chk("size_err", err, 1'b1);
        chk("size_stall", th_stall_mask, 8'h01);
        do_reset();

        arrive(7, 1, 0);
        do_exit(0);
        chk("exit_park_err", err, 1'b1);
        chk("exit_park_active", th_active_mask, 8'h00);
        chk("exit_park_stall", th_stall_mask, 8'h01);
        tick(); tick();

        @(negedge clk);
        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
